// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file and its pending-write scoreboard.
package regfile_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAddrWidth = 5;

    typedef logic [DefAddrWidth-1:0] reg_addr_t;
    typedef logic [DefDataWidth-1:0] reg_data_t;

endpackage

// File: rtl/pending_scoreboard.sv
// Per-register pending bits, set/clear priority, hazard detection and pending count.
module pending_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic                  rs_check_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic                  issue_en_i,
    input  logic [ADDR_WIDTH-1:0] issue_addr_i,
    output logic                  stall_o,
    output logic [ADDR_WIDTH:0]   pending_count_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [Depth-1:0]    pend_q, pend_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                haz1, haz2, waw, accept, wr_ok, inc, dec;

    function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
        return !(ZERO_REG && (a == '0));
    endfunction

    // Pending bit that the current writeback does not retire this cycle.
    function automatic logic live(input logic [ADDR_WIDTH-1:0] a);
        return writable(a) && pend_q[a] && !(wr_en_i && (wr_addr_i == a));
    endfunction

    always_comb begin
        wr_ok   = wr_en_i && writable(wr_addr_i);
        haz1    = rs_check_i && live(rs1_addr_i);
        haz2    = rs_check_i && live(rs2_addr_i);
        waw     = issue_en_i && live(issue_addr_i);
        stall_o = haz1 || haz2 || waw;
        accept  = issue_en_i && !stall_o && writable(issue_addr_i);

        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[wr_addr_i] = 1'b0;
        end
        if (accept) begin
            pend_d[issue_addr_i] = 1'b1;
        end

        // A same-register issue+writeback re-sets a pending bit: neither counts.
        inc = accept && !pend_q[issue_addr_i];
        dec = wr_ok && pend_q[wr_addr_i] && !(accept && (issue_addr_i == wr_addr_i));

        count_d = count_q;
        if (inc && !dec) begin
            count_d = count_q + (ADDR_WIDTH+1)'(1);
        end else if (dec && !inc) begin
            count_d = count_q - (ADDR_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

    assign pending_count_o = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, write bypass and pending-write scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  rs_check,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic                  stall,
    output logic [ADDR_WIDTH:0]   pending_count
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
        return !(ZERO_REG && (a == '0));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a);
        if (!writable(a)) begin
            return '0;
        end else if (wr_en && (wr_addr == a)) begin
            return wr_data;
        end
        return mem_q[a];
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en && writable(wr_addr)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    pending_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_scoreboard (
        .clk_i           (clk),
        .reset_i         (reset),
        .rs1_addr_i      (rs1_addr),
        .rs2_addr_i      (rs2_addr),
        .rs_check_i      (rs_check),
        .wr_en_i         (wr_en),
        .wr_addr_i       (wr_addr),
        .issue_en_i      (issue_en),
        .issue_addr_i    (issue_addr),
        .stall_o         (stall),
        .pending_count_o (pending_count)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: a default-size instance plus a 3-bit-address instance for full-occupancy checks.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [4:0]  rs1_addr, rs2_addr, wr_addr, issue_addr;
    logic [31:0] rs1_data, rs2_data, wr_data;
    logic        rs_check, wr_en, issue_en, stall;
    logic [5:0]  pending_count;

    logic [2:0]  s_rs1_addr, s_rs2_addr, s_wr_addr, s_issue_addr;
    logic [7:0]  s_rs1_data, s_rs2_data, s_wr_data;
    logic        s_rs_check, s_wr_en, s_issue_en, s_stall;
    logic [3:0]  s_pending_count;

    int checks   = 0;
    int failures = 0;

    regfile_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .rs_check      (rs_check),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .issue_en      (issue_en),
        .issue_addr    (issue_addr),
        .stall         (stall),
        .pending_count (pending_count)
    );

    regfile_scoreboard #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3),
        .ZERO_REG   (1'b1)
    ) dut_small (
        .clk           (clk),
        .reset         (reset),
        .rs1_addr      (s_rs1_addr),
        .rs2_addr      (s_rs2_addr),
        .rs1_data      (s_rs1_data),
        .rs2_data      (s_rs2_data),
        .rs_check      (s_rs_check),
        .wr_en         (s_wr_en),
        .wr_addr       (s_wr_addr),
        .wr_data       (s_wr_data),
        .issue_en      (s_issue_en),
        .issue_addr    (s_issue_addr),
        .stall         (s_stall),
        .pending_count (s_pending_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        rs1_addr = '0; rs2_addr = '0; wr_addr = '0; issue_addr = '0; wr_data = '0;
        rs_check = 1'b0; wr_en = 1'b0; issue_en = 1'b0;
        s_rs1_addr = '0; s_rs2_addr = '0; s_wr_addr = '0; s_issue_addr = '0; s_wr_data = '0;
        s_rs_check = 1'b0; s_wr_en = 1'b0; s_issue_en = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        rs1_addr = 5'd5; rs2_addr = 5'd0;
        #1;
        check_eq("reset_r5", rs1_data, 0);
        check_eq("reset_r0", rs2_data, 0);
        check_eq("reset_count", pending_count, 0);
        check_eq("reset_stall", stall, 0);

        // Write with same-cycle bypass, then from array
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEADBEEF; rs1_addr = 5'd3;
        #1;
        check_eq("bypass_r3", rs1_data, 32'hDEADBEEF);
        step();
        wr_en = 1'b0; wr_data = '0;
        #1;
        check_eq("array_r3", rs1_data, 32'hDEADBEEF);
        check_eq("wb_nonpending_count", pending_count, 0);

        // Writes to r0 are dropped, bypass included
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rs1_addr = 5'd0;
        #1;
        check_eq("r0_bypass", rs1_data, 0);
        step();
        wr_en = 1'b0;
        #1;
        check_eq("r0_array", rs1_data, 0);

        // Issue r7, operand hazard, resolved by writeback in the same cycle
        issue_en = 1'b1; issue_addr = 5'd7;
        #1;
        check_eq("issue_r7_stall", stall, 0);
        step();
        issue_en = 1'b0; rs_check = 1'b1; rs2_addr = 5'd7;
        #1;
        check_eq("r7_hazard_stall", stall, 1);
        check_eq("r7_count", pending_count, 1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
        #1;
        check_eq("r7_wb_stall", stall, 0);
        check_eq("r7_wb_bypass", rs2_data, 32'h55);
        step();
        wr_en = 1'b0; rs_check = 1'b0;
        #1;
        check_eq("r7_retired_count", pending_count, 0);
        check_eq("r7_array", rs2_data, 32'h55);

        // WAW on r4, then issue+writeback to r4 in one cycle
        issue_en = 1'b1; issue_addr = 5'd4;
        step();
        #1;
        check_eq("r4_waw_stall", stall, 1);
        check_eq("r4_count", pending_count, 1);
        step();
        check_eq("r4_held_count", pending_count, 1);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        #1;
        check_eq("r4_wb_issue_stall", stall, 0);
        step();
        wr_en = 1'b0; issue_en = 1'b0; rs_check = 1'b1; rs1_addr = 5'd4;
        #1;
        check_eq("r4_reissue_count", pending_count, 1);
        check_eq("r4_still_pending", stall, 1);
        check_eq("r4_data", rs1_data, 32'h44);
        rs_check = 1'b0;

        // Back-to-back issues, then reset discards pending state and data
        issue_en = 1'b1;
        issue_addr = 5'd1; step();
        issue_addr = 5'd2; step();
        issue_addr = 5'd3; step();
        issue_en = 1'b0;
        #1;
        check_eq("pre_reset_count", pending_count, 4);
        reset = 1'b1;
        step();
        reset = 1'b0; rs_check = 1'b1; rs1_addr = 5'd1; rs2_addr = 5'd2;
        #1;
        check_eq("post_reset_count", pending_count, 0);
        check_eq("post_reset_stall_12", stall, 0);
        rs1_addr = 5'd3; rs2_addr = 5'd4;
        #1;
        check_eq("post_reset_stall_34", stall, 0);
        check_eq("post_reset_r3", rs1_data, 0);
        check_eq("post_reset_r4", rs2_data, 0);
        rs_check = 1'b0;

        // Small instance: fill every writable register
        s_issue_en = 1'b1;
        for (int i = 1; i < 8; i++) begin
            s_issue_addr = 3'(i);
            step();
        end
        s_issue_addr = 3'd0;
        #1;
        check_eq("small_full_count", s_pending_count, 7);
        check_eq("small_r0_issue_stall", s_stall, 0);
        step();
        s_issue_en = 1'b0; s_rs_check = 1'b1; s_rs1_addr = 3'd0; s_rs2_addr = 3'd0;
        #1;
        check_eq("small_r0_no_effect", s_pending_count, 7);
        check_eq("small_r0_no_stall", s_stall, 0);
        s_rs1_addr = 3'd6;
        #1;
        check_eq("small_r6_stall", s_stall, 1);
        s_rs_check = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised CPU register file with one write port, two combinational read ports, same-cycle write-to-read bypass, and a per-register pending-write scoreboard. It sits between decode and writeback in the pipelined CPU. Decode reads operands and issues destinations; writeback retires them. The block raises `stall` whenever an operand or destination still has an outstanding producer.

## Interface
Parameters:
- `DATA_WIDTH`, 32: register width in bits.
- `ADDR_WIDTH`, 5: address width; depth = 2**ADDR_WIDTH.
- `ZERO_REG`, 1: when 1, register 0 is hardwired to zero and is never pending.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `rs1_addr`  in  ADDR_WIDTH: read port 1 address.
- `rs2_addr`  in  ADDR_WIDTH: read port 2 address.
- `rs1_data`  out  DATA_WIDTH: read port 1 data, combinational.
- `rs2_data`  out  DATA_WIDTH: read port 2 data, combinational.
- `rs_check`  in  1: decode is presenting valid operands; qualifies operand hazard check.
- `wr_en`  in  1: writeback strobe.
- `wr_addr`  in  ADDR_WIDTH: writeback destination.
- `wr_data`  in  DATA_WIDTH: writeback data.
- `issue_en`  in  1: decode requests to mark `issue_addr` pending.
- `issue_addr`  in  ADDR_WIDTH: destination being issued.
- `stall`  out  1: hazard present; the issue is not accepted this cycle.
- `pending_count`  out  ADDR_WIDTH+1: number of registers currently pending.

## Operation
- **Storage:** `2**ADDR_WIDTH` × `DATA_WIDTH` data array plus one pending bit per register.
- **Zero register:** with `ZERO_REG`=1, writes and issues to address 0 are ignored, reads of address 0 return 0, and address 0 never causes stall.
- **Read:** returns `wr_data` when `wr_en` is high, `wr_addr` equals the read address, and the address is writable (bypass). Otherwise returns the array contents.
- **Write:** on a rising edge with `wr_en` high and a writable address, the array is updated. Pending[`wr_addr`] clears unless the same edge re-sets it (see the issue/writeback rule).
- **clr(a):** `wr_en` high and `wr_addr`==a, with a writable.
- **Operand hazard:** `rs_check` high and rsN pending and not clr(rsN), for N = 1 or 2.
- **WAW hazard:** `issue_en` high and `issue_addr` pending and not clr(`issue_addr`).
- **stall:** the OR of the two operand hazards and the WAW hazard.
- **Accepted issue:** `issue_en` high, `stall` low, and `issue_addr` writable. Sets pending[`issue_addr`] at the edge.
- **Same register, issue and writeback in one cycle:** data is written and pending ends at 1, because the new producer wins.
- **pending_count:**
  - +1 on an accepted issue that sets a bit which ends the cycle newly set.
  - −1 on a writeback that clears a pending bit without a re-set.
  - Both events in one cycle give a net change.
  - Writeback to a non-pending register: data written, count unchanged.
  - Never wraps; its range is 0..2**ADDR_WIDTH.
- **Reset:** the whole data array reads 0, all pending bits are 0, and `pending_count` is 0. Reset overrides a simultaneous write or issue. Reset arriving mid-operation discards all outstanding pending state.

## Timing
- Read latency: 0 cycles, purely combinational from address and write inputs.
- Write visibility: same cycle via bypass; from the array on the cycle after the edge.
- Pending set: visible from the cycle after the accepted-issue edge.
- `stall` is combinational. Decode must hold `issue_en`, `issue_addr` and the operand addresses stable while `stall` is high.
- Outputs after reset: `rs1_data` and `rs2_data` are 0 for any address, `stall` is 0, `pending_count` is 0.

## Structure
- Shared package `regfile_pkg`: default `DATA_WIDTH`/`ADDR_WIDTH` constants, a `reg_addr_t` typedef and a `reg_data_t` typedef.
- Sub-module `pending_scoreboard`: owns the pending bit vector, the set/clear priority, the hazard evaluation and `pending_count`.
- The top level holds the data array, the bypass muxes and the `ZERO_REG` masking.

## Test plan
- Reset, then read r5 and r0 → both return 0; `pending_count`=0; `stall`=0.
- Write r3=0xDEADBEEF with `rs1_addr`=3 in the same cycle → `rs1_data`=0xDEADBEEF that cycle and on the next cycle from the array. Write r0=0x1234 → r0 still reads 0.
- Issue r7; next cycle `rs_check`=1, `rs2_addr`=7 → `stall`=1 and `pending_count`=1. Writeback r7=0x55 in that cycle → `stall`=0 and `rs2_data`=0x55; the cycle after, `pending_count`=0.
- Issue r4 while r4 is pending and no writeback → `stall`=1 and `pending_count` unchanged. Writeback and issue r4 in the same cycle → pending stays 1 and `pending_count` unchanged.
- Issue r1, r2 and r3 on consecutive cycles, then assert `reset` → next cycle `pending_count`=0 and no register pending.
- With `ADDR_WIDTH`=3, issue all seven writable registers → `pending_count`=7. Issuing r0 has no effect.
